// File: rtl/rc4_encrypt_fsm_if.sv
// rc4_encrypt_fsm_if: control handshake plus S-RAM, plaintext RAM and
// ciphertext RAM bus of the RC4 encryptor, bundled as one port.
//   start/key            : run request and 24-bit key (into the encryptor)
//   busy/done            : run status (out of the encryptor)
//   s_address/s_data/s_wren/s_q        : 8x256 working S-RAM port
//   pt_address/pt_q                    : plaintext RAM read port
//   ct_address/ct_data/ct_wren         : ciphertext RAM write port
// master = encryptor side, slave = RAM / controller side.
interface rc4_encrypt_fsm_if;
    logic        start;
    logic [23:0] key;
    logic        busy;
    logic        done;
    logic [7:0]  s_address;
    logic [7:0]  s_data;
    logic        s_wren;
    logic [7:0]  s_q;
    logic [7:0]  pt_address;
    logic [7:0]  pt_q;
    logic [7:0]  ct_address;
    logic [7:0]  ct_data;
    logic        ct_wren;

    modport master (
        input  start, key, s_q, pt_q,
        output busy, done, s_address, s_data, s_wren,
               pt_address, ct_address, ct_data, ct_wren
    );

    modport slave (
        output start, key, s_q, pt_q,
        input  busy, done, s_address, s_data, s_wren,
               pt_address, ct_address, ct_data, ct_wren
    );
endinterface

// File: rtl/rc4_encrypt_fsm.sv
// rc4_encrypt_fsm: single-key RC4 encryptor. On start it fills the external
// S-RAM with the identity permutation, runs the key schedule with the
// captured 24-bit key, then generates MSG_LEN keystream bytes and writes
// plaintext XOR keystream to the ciphertext RAM, pulsing done at the end.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : rc4_encrypt_fsm_if.master (handshake + S/PT/CT RAM ports)
// Every output is registered; its next value is decoded from the next state,
// so an address appears in the same cycle as the state that issues it.
module rc4_encrypt_fsm #(
    parameter int unsigned MSG_LEN = 32
) (
    input  logic              clock,
    input  logic              reset,
    rc4_encrypt_fsm_if.master bus
);

    localparam int unsigned DW     = 8;
    localparam int unsigned KW     = 24;
    localparam logic [DW-1:0] LAST_K = DW'(MSG_LEN - 1);
    localparam logic [DW-1:0] LAST_I = 8'hFF;

    typedef enum logic [4:0] {
        IDLE, INIT,
        KI_RD, KI_WT, KJ_RD, KJ_WT, KW_I, KW_J,
        PI_RD, PI_WT, PJ_RD, PJ_WT, PW_I, PW_J, PF_RD, PF_WT, PC_WR,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   i_q, i_d;
    logic [DW-1:0]   j_q, j_d;
    logic [DW-1:0]   k_q, k_d;
    logic [1:0]      m_q, m_d;          // i mod 3 for key byte selection
    logic [DW-1:0]   si_q, si_d;
    logic [DW-1:0]   sj_q, sj_d;
    logic [KW-1:0]   key_q, key_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   s_address_q, s_address_d;
    logic [DW-1:0]   s_data_q, s_data_d;
    logic            s_wren_q, s_wren_d;
    logic [DW-1:0]   pt_address_q, pt_address_d;
    logic [DW-1:0]   ct_address_q, ct_address_d;
    logic [DW-1:0]   ct_data_q, ct_data_d;
    logic            ct_wren_q, ct_wren_d;

    logic [DW-1:0]   key_byte_c;

    // key[23:16] is byte 0
    always_comb begin
        case (m_q)
            2'd0:    key_byte_c = key_q[23:16];
            2'd1:    key_byte_c = key_q[15:8];
            default: key_byte_c = key_q[7:0];
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            m_q          <= '0;
            si_q         <= '0;
            sj_q         <= '0;
            key_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            s_address_q  <= '0;
            s_data_q     <= '0;
            s_wren_q     <= 1'b0;
            pt_address_q <= '0;
            ct_address_q <= '0;
            ct_data_q    <= '0;
            ct_wren_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            k_q          <= k_d;
            m_q          <= m_d;
            si_q         <= si_d;
            sj_q         <= sj_d;
            key_q        <= key_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            s_address_q  <= s_address_d;
            s_data_q     <= s_data_d;
            s_wren_q     <= s_wren_d;
            pt_address_q <= pt_address_d;
            ct_address_q <= ct_address_d;
            ct_data_q    <= ct_data_d;
            ct_wren_q    <= ct_wren_d;
        end
    end

    // Next state, datapath and next-cycle outputs
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        k_d          = k_q;
        m_d          = m_q;
        si_d         = si_q;
        sj_d         = sj_q;
        key_d        = key_q;
        s_address_d  = s_address_q;
        s_data_d     = s_data_q;
        s_wren_d     = 1'b0;
        pt_address_d = pt_address_q;
        ct_address_d = ct_address_q;
        ct_data_d    = ct_data_q;
        ct_wren_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    key_d       = bus.key;
                    i_d         = '0;
                    j_d         = '0;
                    k_d         = '0;
                    m_d         = '0;
                    state_d     = INIT;
                    s_address_d = '0;
                    s_data_d    = '0;
                    s_wren_d    = 1'b1;
                end
            end
            INIT: begin
                if (i_q == LAST_I) begin
                    i_d         = '0;
                    state_d     = KI_RD;
                    s_address_d = '0;
                end else begin
                    i_d         = i_q + 8'd1;
                    s_address_d = i_q + 8'd1;
                    s_data_d    = i_q + 8'd1;
                    s_wren_d    = 1'b1;
                end
            end
            KI_RD: state_d = KI_WT;
            KI_WT: begin
                si_d        = bus.s_q;
                j_d         = j_q + bus.s_q + key_byte_c;
                s_address_d = j_d;
                state_d     = KJ_RD;
            end
            KJ_RD: state_d = KJ_WT;
            KJ_WT: begin
                sj_d        = bus.s_q;
                s_address_d = i_q;
                s_data_d    = bus.s_q;
                s_wren_d    = 1'b1;
                state_d     = KW_I;
            end
            KW_I: begin
                s_address_d = j_q;
                s_data_d    = si_q;
                s_wren_d    = 1'b1;
                state_d     = KW_J;
            end
            KW_J: begin
                if (i_q == LAST_I) begin
                    // PRGA pre-increments i, so its first index is 1
                    i_d         = 8'd1;
                    j_d         = '0;
                    k_d         = '0;
                    s_address_d = 8'd1;
                    state_d     = PI_RD;
                end else begin
                    i_d         = i_q + 8'd1;
                    m_d         = (m_q == 2'd2) ? 2'd0 : 2'(m_q + 2'd1);
                    s_address_d = i_q + 8'd1;
                    state_d     = KI_RD;
                end
            end
            PI_RD: state_d = PI_WT;
            PI_WT: begin
                si_d        = bus.s_q;
                j_d         = j_q + bus.s_q;
                s_address_d = j_d;
                state_d     = PJ_RD;
            end
            PJ_RD: state_d = PJ_WT;
            PJ_WT: begin
                sj_d        = bus.s_q;
                s_address_d = i_q;
                s_data_d    = bus.s_q;
                s_wren_d    = 1'b1;
                state_d     = PW_I;
            end
            PW_I: begin
                s_address_d = j_q;
                s_data_d    = si_q;
                s_wren_d    = 1'b1;
                state_d     = PW_J;
            end
            PW_J: begin
                // keystream read and plaintext read issued together
                s_address_d  = si_q + sj_q;
                pt_address_d = k_q;
                state_d      = PF_RD;
            end
            PF_RD: state_d = PF_WT;
            PF_WT: begin
                ct_address_d = k_q;
                ct_data_d    = bus.s_q ^ bus.pt_q;
                ct_wren_d    = 1'b1;
                state_d      = PC_WR;
            end
            PC_WR: begin
                if (k_q == LAST_K) begin
                    state_d = DONE;
                end else begin
                    k_d         = k_q + 8'd1;
                    i_d         = i_q + 8'd1;
                    s_address_d = i_q + 8'd1;
                    state_d     = PI_RD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.s_address  = s_address_q;
    assign bus.s_data     = s_data_q;
    assign bus.s_wren     = s_wren_q;
    assign bus.pt_address = pt_address_q;
    assign bus.ct_address = ct_address_q;
    assign bus.ct_data    = ct_data_q;
    assign bus.ct_wren    = ct_wren_q;

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// tb_rc4_encrypt_fsm: drives rc4_encrypt_fsm (MSG_LEN=32 and MSG_LEN=1
// builds) against behavioural S/PT/CT RAMs and checks ciphertext, S-RAM
// state after key scheduling, and handshake timing against an RC4 model.
module tb_rc4_encrypt_fsm;

    localparam int LEN = 32;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    rc4_encrypt_fsm_if bus ();
    rc4_encrypt_fsm_if bus1 ();

    rc4_encrypt_fsm #(.MSG_LEN(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    rc4_encrypt_fsm #(.MSG_LEN(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    logic [7:0] s_mem   [256];
    logic [7:0] pt_mem  [256];
    logic [7:0] ct_mem  [256];
    logic [7:0] s1_mem  [256];
    logic [7:0] ct1_mem [256];

    // one-cycle-latency RAM models
    always @(posedge clock) begin
        if (bus.s_wren) s_mem[bus.s_address] <= bus.s_data;
        bus.s_q  <= s_mem[bus.s_address];
        bus.pt_q <= pt_mem[bus.pt_address];
        if (bus.ct_wren) ct_mem[bus.ct_address] <= bus.ct_data;
    end

    always @(posedge clock) begin
        if (bus1.s_wren) s1_mem[bus1.s_address] <= bus1.s_data;
        bus1.s_q  <= s1_mem[bus1.s_address];
        bus1.pt_q <= pt_mem[bus1.pt_address];
        if (bus1.ct_wren) ct1_mem[bus1.ct_address] <= bus1.ct_data;
    end

    int vectors    = 0;
    int miscompares = 0;
    int exp_ct [256];
    int exp_s  [256];
    logic [7:0] orig [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Textbook RC4 over plain integers, using the current pt_mem
    task automatic model(input logic [23:0] k, input int len);
        int s [256];
        int j, t, ii;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + ((int'(k) >> (8 * (2 - (n % 3)))) & 255)) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        for (int n = 0; n < 256; n++) exp_s[n] = s[n];
        ii = 0;
        j  = 0;
        for (int n = 0; n < len; n++) begin
            ii = (ii + 1) % 256;
            j  = (j + s[ii]) % 256;
            t = s[ii]; s[ii] = s[j]; s[j] = t;
            exp_ct[n] = (s[(s[ii] + s[j]) % 256] ^ int'(pt_mem[n])) & 255;
        end
    endtask

    // One encryption on the 32-byte build. extra: pulse start at cycles 5
    // and 1000 and change key. ksa_chk: compare S-RAM after key schedule.
    // rst_at: assert reset at that cycle and abandon the run.
    task automatic run(input logic [23:0] k, input bit extra, input bit ksa_chk, input int rst_at);
        int cyc, ct_writes, last_ct, bad;
        bit addr_ok, quiet;
        bit [255:0] seen;
        @(negedge clock);
        check("idle_done_low", 32'(bus.done), 0);
        check("idle_busy_low", 32'(bus.busy), 0);
        bus.key   = k;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        cyc = 1;
        check("c1_busy", 32'(bus.busy), 1);
        check("c1_s_wren", 32'(bus.s_wren), 1);
        check("c1_s_address", 32'(bus.s_address), 0);
        check("c1_s_data", 32'(bus.s_data), 0);
        ct_writes = 0;
        last_ct   = 0;
        addr_ok   = 1'b1;
        while (cyc < 2200) begin
            if (bus.ct_wren) begin
                if (bus.ct_address !== 8'(ct_writes)) addr_ok = 1'b0;
                ct_writes++;
                last_ct = cyc;
            end
            if (bus.done) break;
            if (ksa_chk && cyc == 1793) begin
                bad  = 0;
                seen = '0;
                for (int n = 0; n < 256; n++) begin
                    if (s_mem[n] !== 8'(exp_s[n])) bad++;
                    seen[s_mem[n]] = 1'b1;
                end
                check("ksa_state_mismatches", 32'(bad), 0);
                check("ksa_permutation", 32'($countones(seen)), 256);
            end
            if (rst_at != 0 && cyc == rst_at) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                check("rst_busy", 32'(bus.busy), 0);
                check("rst_s_wren", 32'(bus.s_wren), 0);
                check("rst_ct_wren", 32'(bus.ct_wren), 0);
                quiet = 1'b1;
                repeat (20) begin
                    @(negedge clock);
                    if (bus.busy || bus.s_wren || bus.ct_wren || bus.done) quiet = 1'b0;
                end
                check("rst_stays_idle", 32'(quiet), 1);
                check("rst_no_ct_writes", 32'(ct_writes), 0);
                return;
            end
            @(negedge clock);
            cyc++;
            bus.start = extra && (cyc == 5 || cyc == 1000);
            if (extra && cyc == 5) bus.key = ~k;
        end
        bus.start = 1'b0;
        check("done_cycle", 32'(cyc), 32'(1793 + 9 * LEN));
        check("busy_low_in_done", 32'(bus.busy), 0);
        check("ct_write_count", 32'(ct_writes), 32'(LEN));
        check("ct_addr_sequence", 32'(addr_ok), 1);
        check("last_ct_before_done", 32'(last_ct), 32'(cyc - 1));
        for (int n = 0; n < LEN; n++)
            check($sformatf("ct[%0d]", n), 32'(ct_mem[n]), 32'(exp_ct[n]));
    endtask

    task automatic run1(input logic [23:0] k);
        int cyc, writes;
        logic [7:0] wa;
        model(k, 1);
        writes = 0;
        wa = 8'hFF;
        @(negedge clock);
        bus1.key   = k;
        bus1.start = 1'b1;
        @(negedge clock);
        bus1.start = 1'b0;
        cyc = 1;
        while (!bus1.done && cyc < 2200) begin
            if (bus1.ct_wren) begin
                writes++;
                wa = bus1.ct_address;
            end
            @(negedge clock);
            cyc++;
        end
        check("len1_done_cycle", 32'(cyc), 1802);
        check("len1_ct_writes", 32'(writes), 1);
        check("len1_ct_address", 32'(wa), 0);
        check("len1_ct0", 32'(ct1_mem[0]), 32'(exp_ct[0]));
    endtask

    task automatic round_trip(input logic [23:0] k);
        for (int n = 0; n < LEN; n++) orig[n] = pt_mem[n];
        model(k, LEN);
        run(k, 1'b0, 1'b0, 0);
        for (int n = 0; n < LEN; n++) pt_mem[n] = ct_mem[n];
        model(k, LEN);
        run(k, 1'b0, 1'b0, 0);
        for (int n = 0; n < LEN; n++)
            check($sformatf("roundtrip[%0d]", n), 32'(ct_mem[n]), 32'(orig[n]));
    endtask

    initial begin
        string msg;
        logic [23:0] rk;
        msg = "Attack at dawn";
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.key    = '0;
        bus1.start = 1'b0;
        bus1.key   = '0;
        repeat (3) @(negedge clock);
        check("rst_busy0", 32'(bus.busy), 0);
        check("rst_done0", 32'(bus.done), 0);
        check("rst_s_wren0", 32'(bus.s_wren), 0);
        check("rst_ct_wren0", 32'(bus.ct_wren), 0);
        check("rst_addrs0", {8'h0, bus.s_address, bus.pt_address, bus.ct_address}, 0);
        check("rst_data0", {16'h0, bus.s_data, bus.ct_data}, 0);
        reset = 1'b0;

        // known answer, then decrypt by re-encrypting
        for (int n = 0; n < 256; n++)
            pt_mem[n] = (n < msg.len()) ? 8'(msg[n]) : 8'h20;
        model(24'h000102, LEN);
        run(24'h000102, 1'b0, 1'b0, 0);
        for (int n = 0; n < LEN; n++) pt_mem[n] = (n < msg.len()) ? 8'(msg[n]) : 8'h20;
        round_trip(24'h000102);

        for (int n = 0; n < LEN; n++) pt_mem[n] = 8'($urandom);
        round_trip(24'h3FFFFF);

        // all-zero key exercises i==j swaps and j wrap
        model(24'h000000, LEN);
        run(24'h000000, 1'b0, 1'b1, 0);

        // stray starts ignored, then back-to-back run
        rk = 24'($urandom);
        model(rk, LEN);
        run(rk, 1'b1, 1'b0, 0);
        rk = 24'($urandom);
        model(rk, LEN);
        run(rk, 1'b0, 1'b1, 0);

        // reset mid key schedule, then a clean run
        run(24'h123456, 1'b0, 1'b0, 600);
        for (int n = 0; n < LEN; n++) pt_mem[n] = 8'($urandom);
        model(24'h123456, LEN);
        run(24'h123456, 1'b0, 1'b0, 0);

        repeat (2) begin
            for (int n = 0; n < LEN; n++) pt_mem[n] = 8'($urandom);
            rk = 24'($urandom);
            model(rk, LEN);
            run(rk, 1'b0, 1'b0, 0);
        end

        run1(24'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rc4_encrypt_fsm.md
# rc4_encrypt_fsm

Single-key RC4 encryptor: the transmit-side counterpart of the key-search decryptor. Given a 24-bit key and a plaintext message in a read-only RAM, it runs RC4 initialisation, key scheduling and keystream generation on an external 8x256 working S-RAM, and writes the ciphertext to an output RAM. It produces the encrypted test messages the cracker consumes, and it sits beside the cracker on the shared S-RAM bus.

## Interface
Parameters:
- MSG_LEN, 32: message length in bytes (1..256).

Ports:
- clock  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin encryption; sampled only in IDLE.
- key  in  24  secret key, captured when start is accepted; key[23:16] is byte 0, key[15:8] byte 1, key[7:0] byte 2.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the ciphertext is complete.
- s_address  out  8  S-RAM address.
- s_data  out  8  S-RAM write data.
- s_wren  out  1  S-RAM write enable.
- s_q  in  8  S-RAM read data.
- pt_address  out  8  plaintext RAM address.
- pt_q  in  8  plaintext read data.
- ct_address  out  8  ciphertext RAM address.
- ct_data  out  8  ciphertext write data.
- ct_wren  out  1  ciphertext write enable.

## Operation
- All RAMs have one-cycle read latency: an address driven in cycle N gives valid q in cycle N+1. Writes commit at the edge ending the cycle in which wren is high.
- INIT: for i = 0..255, write s[i]=i, one write per cycle.
- KSA: j=0; for i = 0..255: j = j + s[i] + keybyte[i mod 3]; swap s[i], s[j].
  - States KI_RD, KI_WT, KJ_RD, KJ_WT, KW_I, KW_J: 6 cycles per i.
  - s[i] and s[j] are held in registers. KW_I writes s[i]=sj_reg and KW_J writes s[j]=si_reg. When i==j this writes the same value twice, which is correct.
- PRGA: i=0, j=0; for k = 0..MSG_LEN-1:
  - i=i+1; j=j+s[i]; swap; f=s[(si_reg+sj_reg) mod 256]; ct[k]=f XOR pt[k].
  - States PI_RD, PI_WT, PJ_RD, PJ_WT, PW_I, PW_J, PF_RD, PF_WT, PC_WR: 9 cycles per byte.
  - pt_address=k is driven in PF_RD, in parallel with the s[f] read.
  - PC_WR drives ct_address=k, ct_data=s_q XOR pt_q, ct_wren=1.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Arithmetic: all index sums are 8-bit, modulo 256, with wrap-around; carries are discarded. The i mod 3 counter is a separate 2-bit counter that cycles 0,1,2.
- start while busy is ignored. key changes after capture have no effect.
- s_wren is high only in INIT, KW_I, KW_J, PW_I and PW_J. ct_wren is high only in PC_WR.

## Timing
- Reset values: busy=0, done=0, s_wren=0, ct_wren=0, every address output 0, s_data=0, ct_data=0, state IDLE, i=j=0.
- Reset asserted mid-operation returns the block to IDLE on the next edge with no further writes. S-RAM and CT-RAM contents are left as they are.
- Start accepted at edge E0 (start=1 in IDLE). INIT occupies cycles 1..256, KSA cycles 257..1792, PRGA cycles 1793..1792+9*MSG_LEN. done is high in cycle 1793+9*MSG_LEN, which is cycle 2081 for MSG_LEN=32.
- busy is high for cycles 1 through 1792+9*MSG_LEN and low in the done cycle.
- The first S-RAM write (s[0]=0) occurs in cycle 1. The last ciphertext write is in the cycle immediately before done.
- start is accepted again in the cycle after done. Back-to-back runs are allowed.

## Test plan
- Known answer: key=24'h000102, plaintext "Attack at dawn" padded with spaces to 32 bytes, MSG_LEN=32 -> CT-RAM matches a software RC4 model byte for byte, and done occurs exactly 2081 cycles after start.
- Round trip: load the CT-RAM output into the plaintext RAM and re-run with the same key -> the original plaintext is reproduced exactly. Repeat with key=24'h3FFFFF.
- i==j and wrap-around: key=24'h000000 -> matches the model, including iterations where j wraps and where i==j. S-RAM remains a permutation of 0..255 after KSA.
- Handshake: pulse start again at cycles 5 and 1000 of a run -> ignored, with a single done pulse at cycle 2081. A new start in the cycle after done begins a second run.
- Reset mid-KSA at cycle 600 -> the next cycle has busy=0, s_wren=0, ct_wren=0 and no CT-RAM writes. A subsequent start yields the correct ciphertext.
- MSG_LEN=1 build -> exactly one ct_wren pulse at address 0, and done at cycle 1802.
